run_sequencer: RTL and testbench
================================

# run_sequencer

Top-level sequencer that drives the processor's 2-bit `status` mode input and its external data-memory port (`data_in`, `data_addr_in`). It runs one job as a sequence of phases:

- **LOAD:** writes a byte stream from a valid/ready source into data memory.
- **RUN:** lets the processor execute until `end_process`.
- **READ:** streams a fixed window of data memory back out over a valid/ready sink.

It sits between the host-side byte link and the processor instance and is the only block that changes `status`.

## Interface
Parameters:
- `LOAD_BYTES`, default 256: bytes written to data memory per job (addresses 0..LOAD_BYTES-1).
- `READ_BASE`, default 0: first data-memory address read back.
- `READ_BYTES`, default 256: bytes read back per job.
- `RD_LAT`, default 2: cycles from `data_addr_in` change to valid `dm_out`. This covers the processor's registered `dar_out` plus memory latency.
- `WDOG_CYCLES`, default 1_000_000: RUN-phase cycle limit. Used only with `RUN_WATCHDOG_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: the single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: level; sampled in IDLE to begin a job.
- `rx_data` in 8: load byte.
- `rx_valid` in 1: load byte valid.
- `rx_ready` out 1: sequencer accepts the load byte.
- `tx_data` out 8: read-back byte.
- `tx_valid` out 1: read-back byte valid.
- `tx_ready` in 1: sink accepts the byte.
- `status` out 2: processor mode; 00 idle, 10 load, 01 run, 11 read.
- `data_in` out 8: byte written to data memory while `status`=10.
- `data_addr_in` out 16: data-memory address in LOAD and READ.
- `end_process` in 1: processor finished.
- `dm_out` in 8: data-memory read data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a job completes.
- `timeout` out 1: sticky; set on watchdog expiry, cleared on next `start`.

## Operation
States and transitions:
- **IDLE** (`status`=00):
  - `start`=1 moves to LOAD.
  - Address counter is cleared to 0 on entry to LOAD.
- **LOAD** (`status`=10):
  - `rx_ready`=1.
  - On `rx_valid&&rx_ready`: register `rx_data` into `data_in` and the counter into `data_addr_in`, then increment the counter.
  - After byte LOAD_BYTES-1 is accepted, go to LFLUSH.
  - `rx_ready` is combinational from state only, never from `rx_valid`.
- **LFLUSH** (`status`=10, `rx_ready`=0):
  - Holds for 2 cycles so the processor's registered `dm_en`/`bus_out`/`dar_out` commit the last byte.
  - Then go to RUN.
- **RUN** (`status`=01):
  - Wait for `end_process`=1, sampled synchronously, then go to READ.
  - Counter loads READ_BASE on exit.
- **READ** (`status`=11):
  - Per byte: drive `data_addr_in`=counter.
  - Wait RD_LAT+1 cycles using the wait counter.
  - Capture `dm_out` into `tx_data` and assert `tx_valid`.
  - Hold `tx_data`/`tx_valid` stable until `tx_ready`.
  - On handshake: deassert `tx_valid` next cycle and increment the counter.
  - After READ_BYTES handshakes, go to DONE.
- **DONE** (`status`=00): pulse `done` for 1 cycle, then go to IDLE.

Rules:
- `start` is ignored outside IDLE.
- LOAD_BYTES=0 skips LOAD straight to LFLUSH; READ_BYTES=0 skips READ.
- Address arithmetic is 16-bit modulo 2^16; READ_BASE+READ_BYTES wraps past 0xFFFF to 0x0000.
- Reset values: `status`=00, `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `data_in`=0, `data_addr_in`=0, `busy`=0, `done`=0, `timeout`=0; state IDLE; counters 0.
- Reset mid-job aborts immediately, with no partial-byte completion.

## Timing
- `status` changes only on a state transition edge and is registered (no glitches).
- LOAD throughput: 1 byte/cycle with `rx_valid` held high.
- READ throughput: 1 byte per RD_LAT+2 cycles minimum.
- `start` to `status`=10: 1 cycle.
- Last load handshake to `status`=01: 3 cycles.
- `end_process` high to `status`=11: 1 cycle.
- `end_process` already high on entry to RUN: RUN lasts 1 cycle.

## Configuration
- `RUN_WATCHDOG_EN` defined:
  - A 32-bit counter runs in RUN.
  - On reaching WDOG_CYCLES without `end_process`: set `timeout`, skip READ, go to DONE.
- `RUN_WATCHDOG_EN` undefined:
  - No counter is built; RUN waits indefinitely.
  - `timeout` is tied to 0.

## Structure
- Package `run_seq_pkg`:
  - state enum (IDLE, LOAD, LFLUSH, RUN, READ, DONE);
  - status constants `STAT_IDLE`=00, `STAT_RUN`=01, `STAT_LOAD`=10, `STAT_READ`=11;
  - `ADDR_W`=16, `DATA_W`=8.
- One sub-module, `seq_addr_ctr`: 16-bit loadable/clearable wrapping address counter with terminal-count compare.

## Test plan
- LOAD_BYTES=4, bytes A0..A3 back-to-back -> `data_addr_in` 0,1,2,3 with matching `data_in` on consecutive cycles; `status`=01 exactly 3 cycles after the A3 handshake.
- `rx_valid` toggling 1/0 -> no byte lost or duplicated; `rx_ready` stays 1 throughout LOAD.
- READ_BASE=0x10, READ_BYTES=3, memory model with RD_LAT=2, `tx_ready` stalled 5 cycles on byte 2 -> `tx_data` stable during the stall; output is mem[0x10], mem[0x11], mem[0x12]; one `done` pulse.
- READ_BASE=0xFFFE, READ_BYTES=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- `rst_n` low mid-READ -> all outputs at reset values in the same cycle; `start` afterwards runs a full clean job.
- `RUN_WATCHDOG_EN`, WDOG_CYCLES=50, `end_process` never asserted -> `timeout`=1 at cycle 50 of RUN; no `tx_valid`; `done` pulses.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer and its address counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package run_seq_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LFLUSH,
    RUN,
    READ,
    DONE
  } state_t;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_RUN  = 2'b01;
  localparam logic [1:0] STAT_LOAD = 2'b10;
  localparam logic [1:0] STAT_READ = 2'b11;

  // Processor mode presented while the sequencer sits in a given state.
  function automatic logic [1:0] state_status(input state_t s);
    case (s)
      LOAD, LFLUSH: return STAT_LOAD;
      RUN:          return STAT_RUN;
      READ:         return STAT_READ;
      default:      return STAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/seq_addr_ctr.sv
// Loadable/clearable 16-bit wrapping address counter with terminal-count compare.
// Latency: count updates one cycle after clr/load/inc; tc is combinational from the count.
// Backpressure: none; the owner only pulses inc on an accepted transfer.
module seq_addr_ctr
  import run_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  input  logic [ADDR_W-1:0] tc_val,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  // Clear wins over load, load wins over increment; increment wraps at 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/run_sequencer.sv
// Job sequencer: loads data memory from rx, lets the processor run, streams a window back on tx.
// Latency: start->LOAD 1 cycle; last load->RUN 3 cycles; end_process->READ 1 cycle; RD_LAT+2 cycles/read byte.
// Backpressure: rx_ready is high throughout LOAD only; tx holds data/valid until tx_ready. Watchdog: RUN_WATCHDOG_EN.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int LOAD_BYTES  = 256,
  parameter int READ_BASE   = 0,
  parameter int READ_BYTES  = 256,
  parameter int RD_LAT      = 2,
  parameter int WDOG_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] data_addr_in,
  input  logic              end_process,
  input  logic [DATA_W-1:0] dm_out,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(LOAD_BYTES - 1);
  localparam logic [ADDR_W-1:0] RD_FIRST  = ADDR_W'(READ_BASE);
  localparam logic [ADDR_W-1:0] READ_LAST = ADDR_W'(READ_BASE + READ_BYTES - 1);
  localparam logic [7:0]        RD_WAIT   = 8'(RD_LAT);

  state_t            state_q, state_d;
  logic [7:0]        wait_q;
  logic [ADDR_W-1:0] cnt, tc_val;
  logic              tc;
  logic              ctr_clr, ctr_load, ctr_inc;
  logic              wait_inc, ld_take, rd_capture, rd_take;

`ifdef RUN_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  logic [31:0] wdog_q;
  logic        wdog_hit;
`endif

  // The same counter walks load addresses and read addresses; only the limit differs.
  assign tc_val   = (state_q == READ) ? READ_LAST : LOAD_LAST;
  assign rx_ready = (state_q == LOAD);

  seq_addr_ctr u_addr_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ctr_clr),
    .load     (ctr_load),
    .load_val (RD_FIRST),
    .inc      (ctr_inc),
    .tc_val   (tc_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    ctr_clr    = 1'b0;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    wait_inc   = 1'b0;
    ld_take    = 1'b0;
    rd_capture = 1'b0;
    rd_take    = 1'b0;
`ifdef RUN_WATCHDOG_EN
    wdog_hit   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ctr_clr = 1'b1;
          state_d = (LOAD_BYTES == 0) ? LFLUSH : LOAD;
        end
      end
      LOAD: begin
        if (rx_valid) begin
          ld_take = 1'b1;
          ctr_inc = 1'b1;
          if (tc) state_d = LFLUSH;
        end
      end
      LFLUSH: begin
        // Two cycles let the processor's registered write path commit the last byte.
        if (wait_q == 8'd1) state_d = RUN;
        else                wait_inc = 1'b1;
      end
      RUN: begin
        if (end_process) begin
          ctr_load = 1'b1;
          state_d  = (READ_BYTES == 0) ? DONE : READ;
        end
`ifdef RUN_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          wdog_hit = 1'b1;
          state_d  = DONE;
        end
`endif
      end
      READ: begin
        if (!tx_valid) begin
          if (wait_q == RD_WAIT) rd_capture = 1'b1;
          else                   wait_inc   = 1'b1;
        end else if (tx_ready) begin
          rd_take = 1'b1;
          ctr_inc = 1'b1;
          if (tc) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath; status/busy/done follow the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status       <= STAT_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      data_in      <= '0;
      data_addr_in <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      wait_q       <= '0;
    end else begin
      status <= state_status(state_d);
      busy   <= (state_d != IDLE);
      done   <= (state_d == DONE);
      if (ld_take) begin
        data_in      <= rx_data;
        data_addr_in <= cnt;
      end else if (ctr_load) begin
        data_addr_in <= RD_FIRST;
      end else if (rd_take) begin
        data_addr_in <= cnt + ADDR_W'(1);
      end
      if (rd_capture) begin
        tx_data  <= dm_out;
        tx_valid <= 1'b1;
      end else if (rd_take) begin
        tx_valid <= 1'b0;
      end
      if ((state_d != state_q) || rd_take) wait_q <= '0;
      else if (wait_inc)                   wait_q <= wait_q + 8'd1;
    end
  end

`ifdef RUN_WATCHDOG_EN
  // RUN-phase cycle counter and sticky timeout flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      timeout <= 1'b0;
    end else begin
      wdog_q <= (state_q == RUN) ? wdog_q + 32'd1 : 32'd0;
      if ((state_q == IDLE) && start) timeout <= 1'b0;
      else if (wdog_hit)              timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: directed jobs, memory model, decoupled monitor.
// Latency: checks load/run/read phase timing against hand-derived cycle counts.
// Backpressure: sink stalls tx_ready on the second read byte of the first job.
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  status;
  logic [7:0]  data_in;
  logic [15:0] data_addr_in;
  logic        end_process;
  logic [7:0]  dm_out;
  logic        busy;
  logic        done;
  logic        timeout;

  run_sequencer #(
    .LOAD_BYTES  (4),
    .READ_BASE   (16'hFFFE),
    .READ_BYTES  (3),
    .RD_LAT      (2),
    .WDOG_CYCLES (50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .status       (status),
    .data_in      (data_in),
    .data_addr_in (data_addr_in),
    .end_process  (end_process),
    .dm_out       (dm_out),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Data memory: written every cycle while in load mode, two-cycle read latency.
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_d1;
  always @(posedge clk) begin
    if (status == 2'b10) mem[data_addr_in] <= data_in;
    addr_d1 <= data_addr_in;
    dm_out  <= mem[addr_d1];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_tx_addr[$];
  logic [7:0]  exp_ld[$];
  logic [15:0] exp_ld_addr[$];

  bit ld_pend = 1'b0;
  int hs_cnt = 0;
  int done_cnt = 0;
  bit stall_en = 1'b0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares load writes, read-back bytes and done pulses against the queues.
  always @(negedge clk) begin
    if (ld_pend) begin
      if (exp_ld.size() == 0) begin
        chk("load_unexpected", 32'(1), 32'(0));
      end else begin
        chk("load_addr", 32'(data_addr_in), 32'(exp_ld_addr.pop_front()));
        chk("load_data", 32'(data_in), 32'(exp_ld.pop_front()));
      end
    end
    ld_pend = rx_valid && rx_ready && rst_n;
    if (tx_valid) begin
      if (exp_tx.size() == 0) begin
        chk("tx_unexpected", 32'(tx_valid), 32'(0));
      end else begin
        chk("tx_data", 32'(tx_data), 32'(exp_tx[0]));
        chk("tx_addr", 32'(data_addr_in), 32'(exp_tx_addr[0]));
        if (tx_ready) begin
          void'(exp_tx.pop_front());
          void'(exp_tx_addr.pop_front());
          hs_cnt++;
        end
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_status", 32'(status), 32'h0);
    end
  end

  // Sink: ready by default, five stall cycles on the second byte when enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && tx_valid && hs_cnt == 1 && stall_cnt < 5) begin
        tx_ready = 1'b0;
        stall_cnt++;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_status"}, 32'(status), 32'h0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_data_in"}, 32'(data_in), 32'h0);
    chk({tag, "_addr"}, 32'(data_addr_in), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_timeout"}, 32'(timeout), 32'h0);
  endtask

  // mode: 0 normal job, 1 reset mid-READ, 2 end_process never arrives (watchdog)
  task automatic do_job(input logic [31:0] bytes, input bit toggle, input bit stall, input int mode);
    int n;
    for (int i = 0; i < 4; i++) begin
      exp_ld.push_back(bytes[8*i +: 8]);
      exp_ld_addr.push_back(16'(i));
    end
    if (mode == 0) begin
      exp_tx.push_back(8'h5A);        exp_tx_addr.push_back(16'hFFFE);
      exp_tx.push_back(8'hC3);        exp_tx_addr.push_back(16'hFFFF);
      exp_tx.push_back(bytes[7:0]);   exp_tx_addr.push_back(16'h0000);
    end
    hs_cnt    = 0;
    stall_cnt = 0;
    stall_en  = stall;
    n         = done_cnt;

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_status", 32'(status), 32'h2);
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_timeout_clr", 32'(timeout), 32'h0);

    for (int i = 0; i < 4; i++) begin
      if (toggle) begin
        rx_valid = 1'b0;
        cyc();
        chk("rx_ready_gap", 32'(rx_ready), 32'h1);
      end
      rx_valid = 1'b1;
      rx_data  = bytes[8*i +: 8];
      cyc();
      if (i < 3) chk("rx_ready_load", 32'(rx_ready), 32'h1);
    end
    rx_valid = 1'b0;
    chk("flush1_status", 32'(status), 32'h2);
    chk("flush_rx_ready", 32'(rx_ready), 32'h0);
    cyc();
    chk("flush2_status", 32'(status), 32'h2);
    cyc();
    chk("run_status", 32'(status), 32'h1);

    // start is ignored while a job is in progress
    start = 1'b1;
    repeat (3) cyc();
    start = 1'b0;
    chk("run_hold", 32'(status), 32'h1);

    if (mode == 2) begin
      repeat (46) cyc();
      chk("wdog_before", 32'(timeout), 32'h0);
      cyc();
      chk("wdog_timeout", 32'(timeout), 32'h1);
      chk("wdog_done", 32'(done), 32'h1);
      repeat (3) cyc();
      chk("wdog_sticky", 32'(timeout), 32'h1);
      chk("wdog_done_cnt", 32'(done_cnt), 32'(n + 1));
      return;
    end

    end_process = 1'b1;
    cyc();
    end_process = 1'b0;
    chk("read_status", 32'(status), 32'h3);

    if (mode == 1) begin
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      exp_tx.delete();
      exp_tx_addr.delete();
      chk("abort_ld_left", 32'(exp_ld.size()), 32'h0);
      return;
    end

    for (int c = 0; c < 100 && done_cnt == n; c++) @(negedge clk);
    chk("done_seen", 32'(done_cnt), 32'(n + 1));
    cyc();
    chk("done_low", 32'(done), 32'h0);
    cyc();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_status", 32'(status), 32'h0);
    chk("tx_drained", 32'(exp_tx.size()), 32'h0);
    repeat (2) cyc();
    chk("done_once", 32'(done_cnt), 32'(n + 1));
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    end_process = 1'b0;
    mem[16'hFFFE] = 8'h5A;
    mem[16'hFFFF] = 8'hC3;
    #3;
    chk_reset_vals("reset");
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // back-to-back load, stalled read-back, window wraps to address 0
    do_job(32'hA3A2A1A0, 1'b0, 1'b1, 0);
    cyc();

    // reset in the middle of READ, then a clean job with gapped rx_valid
    do_job(32'hB3B2B1B0, 1'b0, 1'b0, 1);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("post_reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("post_reset_status", 32'(status), 32'h0);
    do_job(32'hC3C2C1C0, 1'b1, 1'b0, 0);

`ifdef RUN_WATCHDOG_EN
    do_job(32'hD3D2D1D0, 1'b0, 1'b0, 2);
    repeat (2) cyc();
    do_job(32'hE3E2E1E0, 1'b0, 1'b0, 0);
`endif

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit reached");
  end

endmodule
